// File: rtl/systolic_result_collector_if.sv
// Handshake and data bundle between the systolic array control and the result collector.
// The slave side is the collector; the master side is whatever drives starts and drains results.
interface systolic_result_collector_if #(
    parameter int N = 4,
    parameter int W = 8
);
    logic                          i_start;
    logic                          o_startReady;
    logic [N-1:0][N-1:0][W-1:0]    i_peAcc;
    logic                          o_accClear;
    logic [N-1:0][N-1:0][W-1:0]    o_c;
    logic                          o_validResult;
    logic                          i_resultReady;
    logic                          o_busy;

    modport slave (
        input  i_start, i_peAcc, i_resultReady,
        output o_startReady, o_accClear, o_c, o_validResult, o_busy
    );

    modport master (
        output i_start, i_peAcc, i_resultReady,
        input  o_startReady, o_accClear, o_c, o_validResult, o_busy
    );
endinterface

// File: rtl/systolic_result_collector.sv
// Waits a fixed number of cycles after each start, snapshots every PE accumulator at once,
// presents the matrix under a valid/ready handshake and pulses an accumulator clear.
module systolic_result_collector #(
    parameter int N       = 4,
    parameter int W       = 8,
    parameter int LATENCY = 3*N-2
) (
    input  logic                         i_clk,
    input  logic                         i_arst,
    systolic_result_collector_if.slave   bus
);
    localparam int CNT_W = $clog2(LATENCY) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, COMPUTE, VALID} state_t;

    state_t                       state, state_nxt;
    logic [CNT_W-1:0]             cnt, cnt_nxt;
    logic                         capture;
    logic                         start_ready;
    logic                         acc_clear;
    logic [N-1:0][N-1:0][W-1:0]   c_q;

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        capture     = 1'b0;
        start_ready = 1'b0;
        case (state)
            IDLE: begin
                start_ready = 1'b1;
                if (bus.i_start) begin
                    state_nxt = COMPUTE;
                    cnt_nxt   = '0;
                end
            end
            COMPUTE: begin
                // Counter can reach LATENCY at most, which CNT_W always holds.
                cnt_nxt = cnt + 1'b1;
                if (cnt == LAST) begin
                    capture   = 1'b1;
                    state_nxt = VALID;
                end
            end
            VALID: begin
                start_ready = bus.i_resultReady;
                if (bus.i_resultReady) begin
                    if (bus.i_start) begin
                        state_nxt = COMPUTE;
                        cnt_nxt   = '0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            state     <= IDLE;
            cnt       <= '0;
            acc_clear <= 1'b0;
            c_q       <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            // Clear lands in the first VALID cycle, ahead of any back-to-back operands.
            acc_clear <= capture;
            if (capture) c_q <= bus.i_peAcc;
        end
    end

    assign bus.o_startReady  = start_ready;
    assign bus.o_accClear    = acc_clear;
    assign bus.o_c           = c_q;
    assign bus.o_validResult = (state == VALID);
    assign bus.o_busy        = (state != IDLE);
endmodule
